// File: rtl/resolution_overlay_ctrl.sv
// Resolution label overlay sequencer: fetches one glyph row per line from the char ROM and serialises it MSB-first.
// Optional 2x scaling (bit and row doubling) is enabled by defining RESOLUTION_OVERLAY_SCALE2X_EN.
module resolution_overlay_ctrl #(
    parameter int X_START = 64,
    parameter int Y_START = 32,
    parameter int ROWS    = 16,
    parameter int COLS    = 192
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [1:0]      videoMode,
    input  logic            frame_start,
    input  logic            line_start,
    input  logic [11:0]     hpos,
    input  logic [11:0]     vpos,
    input  logic            de,
    output logic [1:0]      rom_mode,
    output logic [3:0]      rom_addr,
    input  logic [COLS-1:0] rom_q,
    output logic            pixel_on,
    output logic            busy
);

`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
    localparam int S     = 2;
    localparam int LOG_S = 1;
`else
    localparam int S     = 1;
    localparam int LOG_S = 0;
`endif

    localparam int NPIX = COLS * S;
    localparam int CW   = $clog2(COLS * 2 + 1);

    localparam logic [11:0]   X_START_V = 12'(X_START);
    localparam logic [11:0]   Y_START_V = 12'(Y_START);
    localparam logic [11:0]   Y_END_V   = 12'(Y_START + ROWS * S);
    localparam logic [CW-1:0] NPIX_V    = CW'(NPIX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_ARMED,
        ST_SHIFT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [1:0]      r_rom_mode;
    logic [3:0]      r_rom_addr;
    logic [COLS-1:0] r_shreg;
    logic [CW-1:0]   r_col;
    logic            r_pixel_on;

    logic            w_in_range;
    logic            w_fetch;
    logic            w_load;
    logic            w_emit;
    logic            w_shift;

    assign w_in_range = (vpos >= Y_START_V) && (vpos < Y_END_V);

`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
    // Pixel 0 is emitted from ARMED; the register advances after every odd pixel index.
    assign w_shift = (r_state == ST_SHIFT) & r_col[0];
`else
    assign w_shift = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        w_load       = 1'b0;
        w_emit       = 1'b0;
        // A new line always restarts the sequence, whatever was in flight.
        if (line_start) begin
            w_state_next = w_in_range ? ST_FETCH : ST_IDLE;
        end else if (frame_start) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    w_fetch      = 1'b1;
                    w_state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    w_state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    w_load       = 1'b1;
                    w_state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (de && (hpos == X_START_V)) begin
                        w_emit       = 1'b1;
                        w_state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!de || (r_col == NPIX_V)) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_mode <= '0;
            r_rom_addr <= '0;
            r_shreg    <= '0;
            r_col      <= '0;
            r_pixel_on <= 1'b0;
        end else begin
            if (frame_start) begin
                r_rom_mode <= videoMode;
            end
            if (w_fetch) begin
                r_rom_addr <= 4'((vpos - Y_START_V) >> LOG_S);
            end
            if (w_load) begin
                r_shreg <= rom_q;
                r_col   <= '0;
            end else if (w_emit) begin
                r_col <= r_col + CW'(1);
                if (w_shift) begin
                    r_shreg <= {r_shreg[COLS-2:0], 1'b0};
                end
            end
            r_pixel_on <= w_emit & r_shreg[COLS-1];
        end
    end

    assign rom_mode = r_rom_mode;
    assign rom_addr = r_rom_addr;
    assign pixel_on = r_pixel_on;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_resolution_overlay_ctrl.sv
// Bench for resolution_overlay_ctrl: random glyph ROM, directed video lines, per-line expected overlay from the glyph rules.
module tb_resolution_overlay_ctrl;

    localparam int X_START = 64;
    localparam int Y_START = 32;
    localparam int ROWS    = 16;
    localparam int COLS    = 192;
`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int NPIX    = COLS * S;
    localparam int Y_END   = Y_START + ROWS * S;
    localparam int DE_S    = 16;
    localparam int DE_E    = X_START + NPIX + 16;
    localparam int H_TOTAL = DE_E + 8;
    localparam int VW      = NPIX + 2;

    localparam int MODE_1080P = 0;
    localparam int MODE_720P  = 1;
    localparam int MODE_480I  = 2;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      videoMode = 2'd0;
    logic            frame_start = 1'b0;
    logic            line_start = 1'b0;
    logic [11:0]     hpos = '0;
    logic [11:0]     vpos = '0;
    logic            de = 1'b0;
    logic [1:0]      rom_mode;
    logic [3:0]      rom_addr;
    logic [COLS-1:0] rom_q = '0;
    logic            pixel_on;
    logic            busy;

    logic [COLS-1:0] rom_mem [3][ROWS];

    int checks = 0;
    int errors = 0;
    int exp_mode = 0;
    int exp_addr = 0;

    always #5 clock = ~clock;

    // Character ROM: registered read, one clock of latency.
    always @(posedge clock) begin
        rom_q <= (rom_mode < 2'd3) ? rom_mem[rom_mode][rom_addr] : '0;
    end

    resolution_overlay_ctrl #(
        .X_START(X_START),
        .Y_START(Y_START),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .videoMode  (videoMode),
        .frame_start(frame_start),
        .line_start (line_start),
        .hpos       (hpos),
        .vpos       (vpos),
        .de         (de),
        .rom_mode   (rom_mode),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pixel_on   (pixel_on),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input int m);
        videoMode   = 2'(m);
        frame_start = 1'b1;
        line_start  = 1'b0;
        hpos        = '0;
        vpos        = '0;
        de          = 1'b0;
        @(posedge clock);
        #1;
        exp_mode    = m;
        frame_start = 1'b0;
        chk("frame_rom_mode", 400'(rom_mode), 400'(exp_mode));
        chk("frame_busy", 400'(busy), 400'(0));
        $display("frame mode=%0d", m);
    endtask

    // Drives one video line; stop_h < H_TOTAL cuts it short, rst_col >= 0 pulses reset after that column.
    task automatic run_line(input int v, input bit fs, input int stop_h, input int rst_col);
        logic [399:0] obs;
        logic [399:0] expv;
        int           outside;
        bit           inr;
        bit           rst_hit;
        int           row;
        int           idx;
        inr     = (v >= Y_START) && (v < Y_END);
        row     = inr ? (v - Y_START) / S : 0;
        obs     = '0;
        expv    = '0;
        outside = 0;
        rst_hit = 1'b0;
        for (int h = 0; h < stop_h; h++) begin
            frame_start = fs && (h == 0);
            line_start  = (h == 0);
            vpos        = 12'(v);
            hpos        = 12'(h);
            de          = (h >= DE_S) && (h < DE_E);
            if (fs && h == 0) exp_mode = int'(videoMode);
            @(posedge clock);
            #1;
            if (h == 0) begin
                chk("ls_busy", 400'(busy), 400'(inr));
                chk("ls_pixel_off", 400'(pixel_on), 400'(0));
                if (fs) chk("fs_ls_rom_mode", 400'(rom_mode), 400'(exp_mode));
            end
            if (h == 1) begin
                if (inr) exp_addr = row;
                chk("rom_addr", 400'(rom_addr), 400'(exp_addr));
            end
            if (h >= X_START - 1 && h <= X_START + NPIX) begin
                idx      = VW - 1 - (h - X_START + 1);
                obs[idx] = pixel_on;
                if (!rst_hit && inr && h >= X_START && h < X_START + NPIX)
                    expv[idx] = rom_mem[exp_mode][row][COLS - 1 - (h - X_START) / S];
            end else if (pixel_on) begin
                outside++;
            end
            if (rst_hit && h == X_START + rst_col + 1) reset_n = 1'b1;
            if (rst_col >= 0 && h == X_START + rst_col) begin
                reset_n = 1'b0;
                #1;
                chk("rst_pixel_on", 400'(pixel_on), 400'(0));
                chk("rst_busy", 400'(busy), 400'(0));
                chk("rst_rom_mode", 400'(rom_mode), 400'(0));
                chk("rst_rom_addr", 400'(rom_addr), 400'(0));
                rst_hit  = 1'b1;
                exp_mode = 0;
                exp_addr = 0;
            end
        end
        frame_start = 1'b0;
        line_start  = 1'b0;
        chk("pixel_row", obs, expv);
        chk("pixel_outside", 400'(outside), 400'(0));
        if (stop_h == H_TOTAL) chk("eol_busy", 400'(busy), 400'(0));
        $display("line vpos=%0d mode=%0d fetch=%0d row=%0d len=%0d", v, exp_mode, inr, row, stop_h);
    endtask

    initial begin
        for (int m = 0; m < 3; m++)
            for (int r = 0; r < ROWS; r++)
                for (int w = 0; w < COLS / 32; w++)
                    rom_mem[m][r][w*32 +: 32] = $urandom;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_rom_mode", 400'(rom_mode), 400'(0));
        chk("reset_rom_addr", 400'(rom_addr), 400'(0));
        chk("reset_pixel_on", 400'(pixel_on), 400'(0));
        chk("reset_busy", 400'(busy), 400'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        do_frame(MODE_720P);
        run_line(Y_START - 1, 1'b0, H_TOTAL, -1);
        run_line(Y_START,     1'b0, H_TOTAL, -1);
        run_line(Y_START + 1, 1'b0, H_TOTAL, -1);
        run_line(Y_END - 1,   1'b0, H_TOTAL, -1);
        run_line(Y_END,       1'b0, H_TOTAL, -1);

        do_frame(MODE_1080P);
        run_line(Y_START, 1'b0, H_TOTAL, -1);
        videoMode = 2'(MODE_720P);
        run_line(Y_START + 8 * S,  1'b0, H_TOTAL, -1);
        run_line(Y_START + 9 * S,  1'b0, X_START + 101, -1);
        run_line(Y_START + 10 * S, 1'b0, H_TOTAL, -1);
        run_line(Y_START + 11 * S, 1'b0, H_TOTAL, 50);
        run_line(Y_START + 12 * S, 1'b0, H_TOTAL, -1);

        videoMode = 2'(MODE_480I);
        run_line(Y_START + 3, 1'b1, H_TOTAL, -1);

        for (int i = 0; i < 6; i++) begin
            do_frame(int'($urandom_range(2, 0)));
            for (int j = 0; j < 2; j++)
                run_line(int'($urandom_range(Y_END + 1, Y_START - 2)), 1'b0, H_TOTAL, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
